prime_job_sched: RTL and testbench

Job scheduler that shares one prime-search engine (N-th prime datapath behind the GPIO emulator bus) between NREQ requesters. It accepts one job at a time under round-robin arbitration, starts the engine, and watches completion with a cycle timeout. It returns the result tagged with the requester id. It sits between the bus-side command decode and the prime engine, replacing direct start writes to the engine.

---
 rtl/prime_job_sched_pkg.sv | 16 +
 rtl/prime_job_sched_if.sv | 40 ++++
 rtl/prime_job_sched_arbiter.sv | 30 +++
 rtl/prime_job_sched.sv | 117 +++++++++++
 tb/tb_prime_job_sched.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prime_job_sched_pkg.sv
// Shared types and constants for the prime-search job scheduler.
package prime_sched_pkg;

    localparam int IDX_W = 32;
    localparam int CNT_W = 20;

    localparam logic [IDX_W-1:0] ERR_RESULT = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT     = 2'd2,
        RESPOND  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/prime_job_sched_if.sv
// Bundle of requester, engine and response signals around the job scheduler.
interface prime_job_sched_if
    import prime_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*IDX_W-1:0] req_index;
    logic [NREQ-1:0]       req_ready;

    logic                  eng_start;
    logic [IDX_W-1:0]      eng_index;
    logic                  eng_abort;
    logic                  eng_done;
    logic [IDX_W-1:0]      eng_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [IDX_W-1:0]      rsp_result;
    logic                  rsp_err;
    logic                  busy;

    // Environment side: requesters, engine and response consumer
    modport master (
        output req_valid, req_index, eng_done, eng_result, rsp_ready,
        input  req_ready, eng_start, eng_index, eng_abort,
               rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_index, eng_done, eng_result, rsp_ready,
        output req_ready, eng_start, eng_index, eng_abort,
               rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

endinterface

// File: rtl/prime_job_sched_arbiter.sv
// Combinational round-robin arbiter; the last-grant pointer is kept by the caller.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_id
);

    // Pick the first active request after last_grant, wrapping around
    always_comb begin
        int   idx;
        logic found;
        grant_onehot = '0;
        grant_id     = '0;
        found        = 1'b0;
        idx          = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_id          = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/prime_job_sched.sv
// Shares one prime-search engine between NREQ requesters, one job at a time,
// with a cycle timeout and id-tagged responses.
module prime_job_sched
    import prime_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 65535
) (
    input logic              clk,
    input logic              n_reset,
    prime_job_sched_if.slave bus
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_DISPATCH = DISPATCH;
    localparam logic [1:0] S_WAIT     = WAIT;
    localparam logic [1:0] S_RESPOND  = RESPOND;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDW-1:0]   LAST_INIT = IDW'(NREQ - 1);

    logic [1:0]       state;
    logic [IDW-1:0]   last_grant;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] eng_index;
    logic [IDW-1:0]   rsp_id;
    logic [IDX_W-1:0] rsp_result;
    logic             rsp_err;

    logic [NREQ-1:0]  grant_onehot;
    logic [IDW-1:0]   grant_id;
    logic             grant_valid;
    logic [IDX_W-1:0] sel_index;
    logic             in_idle;
    logic             timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req          (bus.req_valid),
        .last_grant   (last_grant),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id)
    );

    assign grant_valid = |grant_onehot;
    assign sel_index   = bus.req_index[int'(grant_id)*IDX_W +: IDX_W];
    assign in_idle     = (state == S_IDLE) && n_reset;
    assign timeout_hit = (cnt == CNT_LAST);

    assign bus.req_ready  = in_idle ? grant_onehot : '0;
    assign bus.eng_start  = (state == S_DISPATCH);
    assign bus.eng_abort  = (state == S_WAIT) && !bus.eng_done && timeout_hit;
    assign bus.eng_index  = eng_index;
    assign bus.rsp_valid  = (state == S_RESPOND);
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_err    = rsp_err;
    assign bus.busy       = (state != S_IDLE);

    // Job FSM: accept, start engine, watch done/timeout, hold response until taken
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= S_IDLE;
            last_grant <= LAST_INIT;
            cnt        <= '0;
            eng_index  <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        rsp_id    <= grant_id;
                        eng_index <= sel_index;
                        if (sel_index == '0) begin
                            rsp_result <= ERR_RESULT;
                            rsp_err    <= 1'b1;
                            state      <= S_RESPOND;
                        end else begin
                            state <= S_DISPATCH;
                        end
                    end
                end
                S_DISPATCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (bus.eng_done) begin
                        rsp_result <= bus.eng_result;
                        rsp_err    <= 1'b0;
                        state      <= S_RESPOND;
                    end else if (timeout_hit) begin
                        rsp_result <= ERR_RESULT;
                        rsp_err    <= 1'b1;
                        state      <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (bus.rsp_ready) begin
                        last_grant <= rsp_id;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_job_sched.sv
// Directed self-checking bench for prime_job_sched: one instance with the
// default timeout and one with TIMEOUT=16 for the timeout/collision cases.
module tb_prime_job_sched;

    logic clk = 1'b0;
    logic n_reset;

    int tests_run    = 0;
    int tests_failed = 0;

    prime_job_sched_if #(.NREQ(4), .IDW(2)) a_if ();
    prime_job_sched_if #(.NREQ(4), .IDW(2)) b_if ();

    prime_job_sched #(.NREQ(4), .IDW(2)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (a_if.slave)
    );

    prime_job_sched #(.NREQ(4), .IDW(2), .TIMEOUT(16)) dut_to (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (b_if.slave)
    );

    always #5 clk = ~clk;

    // Reference prime generator used by the engine stand-in
    function automatic logic [31:0] nth_prime(input logic [31:0] n);
        int found;
        int cand;
        bit is_p;
        if (n == 0 || n > 200) return 32'hDEAD_BEEF;
        found = 0;
        cand  = 1;
        while (found < int'(n)) begin
            cand++;
            is_p = 1'b1;
            for (int d = 2; d * d <= cand; d++) begin
                if (cand % d == 0) is_p = 1'b0;
            end
            if (is_p) found++;
        end
        return 32'(cand);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] valid, input logic [127:0] idx);
        a_if.req_valid = valid;
        a_if.req_index = idx;
    endtask

    // Starts from a falling edge in IDLE with requests applied; runs one full job
    task automatic do_job(input string tag, input int exp_id, input logic [31:0] exp_idx,
                          input int delay, input logic [31:0] exp_res,
                          input logic [3:0] valid_after);
        #1;
        check_output({tag, "_req_ready"}, 32'(a_if.req_ready), 32'(1 << exp_id));
        @(negedge clk);
        a_if.req_valid = valid_after;
        check_output({tag, "_eng_start"}, 32'(a_if.eng_start), 32'd1);
        check_output({tag, "_eng_index"}, a_if.eng_index, exp_idx);
        check_output({tag, "_ready_busy"}, 32'(a_if.req_ready), 32'd0);
        for (int d = 1; d <= delay; d++) begin
            @(negedge clk);
            if (d == 1) check_output({tag, "_start_1cyc"}, 32'(a_if.eng_start), 32'd0);
            if (d == delay) begin
                a_if.eng_done   = 1'b1;
                a_if.eng_result = nth_prime(a_if.eng_index);
            end
        end
        @(negedge clk);
        a_if.eng_done   = 1'b0;
        a_if.eng_result = '0;
        check_output({tag, "_rsp_valid"}, 32'(a_if.rsp_valid), 32'd1);
        check_output({tag, "_rsp_id"}, 32'(a_if.rsp_id), 32'(exp_id));
        check_output({tag, "_rsp_result"}, a_if.rsp_result, exp_res);
        check_output({tag, "_rsp_err"}, 32'(a_if.rsp_err), 32'd0);
        a_if.rsp_ready = 1'b1;
        @(negedge clk);
        a_if.rsp_ready = 1'b0;
        check_output({tag, "_idle"}, 32'(a_if.busy), 32'd0);
    endtask

    // Checks that every scheduler output of instance a is zero
    task automatic check_all_zero(input string tag);
        check_output({tag, "_req_ready"}, 32'(a_if.req_ready), 32'd0);
        check_output({tag, "_eng_start"}, 32'(a_if.eng_start), 32'd0);
        check_output({tag, "_eng_index"}, a_if.eng_index, 32'd0);
        check_output({tag, "_eng_abort"}, 32'(a_if.eng_abort), 32'd0);
        check_output({tag, "_rsp_valid"}, 32'(a_if.rsp_valid), 32'd0);
        check_output({tag, "_rsp_id"}, 32'(a_if.rsp_id), 32'd0);
        check_output({tag, "_rsp_result"}, a_if.rsp_result, 32'd0);
        check_output({tag, "_rsp_err"}, 32'(a_if.rsp_err), 32'd0);
        check_output({tag, "_busy"}, 32'(a_if.busy), 32'd0);
    endtask

    initial begin
        int abort_cnt;
        int abort_at;
        int rsp_at;

        n_reset = 1'b0;
        a_if.req_valid = '0; a_if.req_index = '0; a_if.eng_done = 1'b0;
        a_if.eng_result = '0; a_if.rsp_ready = 1'b0;
        b_if.req_valid = '0; b_if.req_index = '0; b_if.eng_done = 1'b0;
        b_if.eng_result = '0; b_if.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        a_if.req_valid = 4'b1111;
        #1;
        check_all_zero("reset");
        a_if.req_valid = '0;
        n_reset = 1'b1;
        @(negedge clk);

        // Single job: requester 0, N=5, engine answers after 40 cycles
        apply_stimulus(4'b0001, {96'd0, 32'd5});
        do_job("single", 0, 32'd5, 40, 32'd11, 4'b0000);

        // Round-robin from a fresh reset with every requester asking
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        apply_stimulus(4'b1111, {32'd10, 32'd3, 32'd2, 32'd1});
        do_job("rr0", 0, 32'd1, 3, 32'd2, 4'b1111);
        do_job("rr1", 1, 32'd2, 4, 32'd3, 4'b1111);
        do_job("rr2", 2, 32'd3, 5, 32'd5, 4'b1111);
        do_job("rr3", 3, 32'd10, 6, 32'd29, 4'b1111);
        do_job("rr4", 0, 32'd1, 3, 32'd2, 4'b0000);

        // Index 0 from requester 2 answers immediately with an error
        apply_stimulus(4'b0100, 128'd0);
        #1;
        check_output("idx0_req_ready", 32'(a_if.req_ready), 32'b0100);
        @(negedge clk);
        a_if.req_valid = '0;
        check_output("idx0_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
        check_output("idx0_no_start", 32'(a_if.eng_start), 32'd0);
        check_output("idx0_rsp_id", 32'(a_if.rsp_id), 32'd2);
        check_output("idx0_rsp_err", 32'(a_if.rsp_err), 32'd1);
        check_output("idx0_rsp_result", a_if.rsp_result, 32'd0);
        a_if.rsp_ready = 1'b1;
        @(negedge clk);
        a_if.rsp_ready = 1'b0;
        check_output("idx0_done", 32'(a_if.rsp_valid), 32'd0);

        // Backpressure: requester 1 job, response held for 10 cycles
        apply_stimulus(4'b0010, {32'd0, 32'd0, 32'd4, 32'd0});
        #1;
        check_output("bp_req_ready", 32'(a_if.req_ready), 32'b0010);
        @(negedge clk);
        apply_stimulus(4'b0001, {32'd0, 32'd0, 32'd4, 32'd6});
        check_output("bp_eng_index", a_if.eng_index, 32'd4);
        repeat (5) @(negedge clk);
        a_if.eng_done   = 1'b1;
        a_if.eng_result = nth_prime(a_if.eng_index);
        @(negedge clk);
        a_if.eng_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_output("bp_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
            check_output("bp_rsp_id", 32'(a_if.rsp_id), 32'd1);
            check_output("bp_rsp_result", a_if.rsp_result, 32'd7);
            check_output("bp_rsp_err", 32'(a_if.rsp_err), 32'd0);
            check_output("bp_req_ready", 32'(a_if.req_ready), 32'd0);
            @(negedge clk);
        end
        a_if.rsp_ready = 1'b1;
        @(negedge clk);
        a_if.rsp_ready = 1'b0;

        // Requester 0 job, then reset in the middle of WAIT
        #1;
        check_output("rst_job_req_ready", 32'(a_if.req_ready), 32'b0001);
        @(negedge clk);
        a_if.req_valid = '0;
        check_output("rst_job_eng_index", a_if.eng_index, 32'd6);
        repeat (3) @(negedge clk);
        a_if.req_valid = 4'b1111;
        n_reset = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        check_output("post_reset_grant", 32'(a_if.req_ready), 32'b0001);
        a_if.req_valid = '0;
        @(negedge clk);

        // Timeout instance: engine never answers
        b_if.req_valid = 4'b0001;
        b_if.req_index = {96'd0, 32'd7};
        #1;
        check_output("to_req_ready", 32'(b_if.req_ready), 32'b0001);
        @(negedge clk);
        b_if.req_valid = '0;
        check_output("to_eng_start", 32'(b_if.eng_start), 32'd1);
        abort_cnt = 0;
        abort_at  = 0;
        rsp_at    = 0;
        for (int w = 1; w <= 30; w++) begin
            @(negedge clk);
            if (b_if.eng_abort) begin
                abort_cnt++;
                abort_at = w;
            end
            if (b_if.rsp_valid) begin
                rsp_at = w;
                break;
            end
        end
        check_output("to_abort_count", 32'(abort_cnt), 32'd1);
        check_output("to_abort_cycle", 32'(abort_at), 32'd16);
        check_output("to_rsp_cycle", 32'(rsp_at), 32'd17);
        check_output("to_rsp_err", 32'(b_if.rsp_err), 32'd1);
        check_output("to_rsp_result", b_if.rsp_result, 32'd0);
        check_output("to_rsp_id", 32'(b_if.rsp_id), 32'd0);
        b_if.rsp_ready = 1'b1;
        @(negedge clk);
        b_if.rsp_ready = 1'b0;

        // Done arrives in the same cycle the timeout would fire
        b_if.req_valid = 4'b0010;
        b_if.req_index = {32'd0, 32'd0, 32'd8, 32'd0};
        #1;
        check_output("col_req_ready", 32'(b_if.req_ready), 32'b0010);
        @(negedge clk);
        b_if.req_valid = '0;
        check_output("col_eng_start", 32'(b_if.eng_start), 32'd1);
        abort_cnt = 0;
        for (int w = 1; w <= 16; w++) begin
            @(negedge clk);
            if (w == 16) begin
                b_if.eng_done   = 1'b1;
                b_if.eng_result = nth_prime(b_if.eng_index);
                #1;
            end
            if (b_if.eng_abort) abort_cnt++;
        end
        check_output("col_no_abort", 32'(abort_cnt), 32'd0);
        @(negedge clk);
        b_if.eng_done = 1'b0;
        check_output("col_rsp_valid", 32'(b_if.rsp_valid), 32'd1);
        check_output("col_rsp_err", 32'(b_if.rsp_err), 32'd0);
        check_output("col_rsp_result", b_if.rsp_result, 32'd19);
        check_output("col_rsp_id", 32'(b_if.rsp_id), 32'd1);
        b_if.rsp_ready = 1'b1;
        @(negedge clk);
        b_if.rsp_ready = 1'b0;
        check_output("col_idle", 32'(b_if.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
